sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one synchronous sprite ROM (1-cycle read latency, 32×32 4-bit palette indices) between several per-pixel renderers (tank 1, tank 2, bullets) in the VGA pixel domain. Performs round-robin arbitration with optional burst locking, drives the single ROM address port, and returns each read tagged with its requester ID. It sits between the sprite renderers and the shared ROM/palette pair, so each renderer no longer needs its own ROM copy.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM data (palette index) width
- MAX_BURST, 32, max consecutive grants to one locked requester (1..255)
- vga_clk  in  1  single clock for the block; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; held until granted
- lock  in  NUM_REQ  per-requester burst hold; meaningful only with req
- addr  in  NUM_REQ*ADDR_W  requester i's address in bits [i*ADDR_W +: ADDR_W]; stable while req is high
- gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit set
- rom_address  out  ADDR_W  to ROM address port
- rom_q  in  DATA_W  ROM output, valid the cycle after its address is presented
- rd_valid  out  1  registered; read data returned this cycle
- rd_id  out  $clog2(NUM_REQ)  registered; requester owning rd_data
- rd_data  out  DATA_W  registered; returned palette index

## Operation
- Pointer ptr (registered) names the highest-priority requester. Winner = first i with req[i] set, scanning ptr, ptr+1, … modulo NUM_REQ.
- Burst lock: owner (registered ID) plus burst counter bcnt. If the previous cycle's winner w had lock[w]=1, req[w] is still 1, and bcnt < MAX_BURST, w wins again regardless of ptr.
- FSM, two states:
  - ARB: normal round-robin. On grant to w with lock[w]=0, set ptr←(w+1) mod NUM_REQ. On grant with lock[w]=1, go to BURST with owner←w, bcnt←1, ptr unchanged.
  - BURST: if req[owner]&lock[owner]&(bcnt<MAX_BURST), grant owner and increment bcnt. Otherwise return to ARB and arbitrate the same cycle, with ptr←(owner+1) mod NUM_REQ used for that arbitration. The owner is excluded when the exit was caused by bcnt==MAX_BURST.
- No request: gnt=0, ptr and state unchanged (ARB stays ARB; BURST exits to ARB with ptr←owner+1).
- rom_address = addr slice of winner. With no grant, it holds the last granted address (registered copy) so ROM output is stable.
- Read pipeline: a tag register (valid, id) is captured at the grant edge. On the next edge, rd_valid←tag.valid, rd_id←tag.id, rd_data←rom_q.
- rd_valid=0 cycles leave rd_id and rd_data holding their previous values.

## Timing
- Grant in cycle N (gnt high while req high, same cycle, combinational). Requester may drop or change req/addr from cycle N+1.
- ROM samples the address at the end of N. rom_q is valid in N+1. rd_valid/rd_id/rd_data are high/valid in N+2. Fixed latency 2, throughput 1 read/cycle.
- Back-to-back grants to different requesters produce back-to-back rd_valid in order of grant.
- Reset (async, any cycle):
  - gnt=0 and rom_address=0 while Reset is high.
  - rd_valid=0, rd_id=0, rd_data=0, ptr=0, state ARB, bcnt=0, tag cleared.
  - In-flight reads are discarded, so no rd_valid appears after reset deassertion unless a new grant occurs.
- bcnt width is $clog2(MAX_BURST+1). It saturates at MAX_BURST and never wraps.
- Simultaneous lock drop and new requests: arbitration uses ptr←owner+1 in that same cycle. There are no idle cycles.

## Structure
- Package sprite_arb_pkg: NUM_REQ, ADDR_W, DATA_W, MAX_BURST defaults, req_id_t typedef, arb_state_t enum {ARB, BURST}.
- Sub-module rr_picker: combinational. Inputs: req vector and start pointer. Outputs: one-hot winner and found flag. Instantiated once.

## Test plan
- Reset, then req=3'b001, addr0=10'd5 for 1 cycle -> gnt=001 in that cycle; rd_valid=1, rd_id=0, rd_data=ROM[5] two cycles later.
- req=3'b111 held for 6 cycles, no lock -> grant order 0,1,2,0,1,2; rd_id follows the same order, each 2 cycles later.
- req0+lock0 held, req1 high, MAX_BURST=4 -> gnt0 for 4 cycles, then gnt1 in cycle 5, then gnt0 again once req1 drops.
- Lock0 dropped after 2 burst grants with req2 pending -> gnt2 in the very next cycle, with no idle cycle.
- Reset asserted mid-cycle between grant and return -> rd_valid stays 0 after release; ptr=0, so req=3'b110 grants requester 1 first.
- req=0 for 5 cycles after a grant at addr 10'd77 -> gnt=0, rom_address holds 77, rd_valid pulses once only.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_arb_pkg
// Purpose  : Shared defaults and types for the sprite ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_arb_pkg;

    localparam int NUM_REQ_DEFAULT   = 3;
    localparam int ADDR_W_DEFAULT    = 10;
    localparam int DATA_W_DEFAULT    = 4;
    localparam int MAX_BURST_DEFAULT = 32;

    typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational rotating-priority picker. Returns the first set
//            request found scanning from start upward, modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import sprite_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [NUM_REQ-1:0] win,
    output logic               found
);

    logic [ID_W-1:0] idx;

    // Scan all requesters beginning at start; first hit wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(start) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Purpose  : Round-robin arbiter with burst locking that shares one
//            synchronous sprite ROM between several pixel renderers and
//            returns each read tagged with the requester ID.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEFAULT,
    parameter  int ADDR_W    = ADDR_W_DEFAULT,
    parameter  int DATA_W    = DATA_W_DEFAULT,
    parameter  int MAX_BURST = MAX_BURST_DEFAULT,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int                 BCNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0]  BMAX    = BCNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic                tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]     tag_id_q, tag_id_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ID_W-1:0]     rd_id_q, rd_id_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                burst_cont;
    logic [NUM_REQ-1:0]  pick_req;
    logic [ID_W-1:0]     pick_start;
    logic [NUM_REQ-1:0]  pick_win;
    logic                pick_found;
    logic [NUM_REQ-1:0]  win_oh;
    logic [ID_W-1:0]     win_id;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_lock;
    logic                granted;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
        return (p == LAST_ID) ? '0 : p + 1'b1;
    endfunction

    // Decide whether the burst owner keeps the port, otherwise set up the
    // round-robin scan (restarting after the owner when a burst just ended).
    always_comb begin
        burst_cont = (state_q == BURST) && req[owner_q] && lock[owner_q]
                     && (bcnt_q < BMAX);
        pick_req   = req;
        pick_start = ptr_q;
        if (state_q == BURST && !burst_cont) begin
            pick_start = wrap_inc(owner_q);
            if (bcnt_q == BMAX) begin
                pick_req[owner_q] = 1'b0;
            end
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (pick_req),
        .start (pick_start),
        .win   (pick_win),
        .found (pick_found)
    );

    // Winner selection, FSM next state, ROM address and read-pipeline inputs.
    always_comb begin
        win_oh = '0;
        if (burst_cont) begin
            win_oh[owner_q] = 1'b1;
        end else begin
            win_oh = pick_win;
        end
        granted = |win_oh;

        win_id   = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_id   = win_id | ID_W'(i);
                win_addr = win_addr | addr[i*ADDR_W +: ADDR_W];
            end
        end
        win_lock = |(lock & win_oh);

        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        if (burst_cont) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
        end else begin
            state_d = ARB;
            ptr_d   = pick_start;
            bcnt_d  = '0;
            if (pick_found) begin
                if (win_lock) begin
                    state_d = BURST;
                    owner_d = win_id;
                    bcnt_d  = BCNT_W'(1);
                end else begin
                    ptr_d = wrap_inc(win_id);
                end
            end
        end

        last_addr_d = granted ? win_addr : last_addr_q;
        tag_valid_d = granted;
        tag_id_d    = granted ? win_id : tag_id_q;
        rd_valid_d  = tag_valid_q;
        rd_id_d     = tag_valid_q ? tag_id_q : rd_id_q;
        rd_data_d   = tag_valid_q ? rom_q : rd_data_q;

        gnt         = Reset ? '0 : win_oh;
        rom_address = Reset ? '0 : last_addr_d;
    end

    // State register; reset discards any in-flight read.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            bcnt_q      <= '0;
            last_addr_q <= '0;
            tag_valid_q <= 1'b0;
            tag_id_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_id_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            bcnt_q      <= bcnt_d;
            last_addr_q <= last_addr_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            rd_valid_q  <= rd_valid_d;
            rd_id_q     <= rd_id_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Purpose  : Self-checking bench for sprite_rom_arbiter: directed scenarios
//            followed by random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            vga_clk = 1'b0;
    logic            Reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_q;
    logic            rd_valid;
    logic [IW-1:0]   rd_id;
    logic [DW-1:0]   rd_data;

    int checks = 0;
    int errors = 0;
    int a [N];

    // Reference state: round-robin pointer, last winner, locked run length,
    // held ROM address and the two-stage read return.
    int m_ptr, m_prev, m_run, m_last;
    bit t_v;
    int t_id, t_addr;
    bit m_rv;
    int m_rid, m_rdata;

    sprite_rom_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .req         (req),
        .lock        (lock),
        .addr        (addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int rom_fn(input int ad);
        return (ad * 7 + (ad >> 5) * 3 + 1) % 16;
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge vga_clk) rom_q <= DW'(rom_fn(int'(rom_address)));

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_prev = 0; m_run = 0; m_last = 0;
        t_v = 1'b0; t_id = 0; t_addr = 0;
        m_rv = 1'b0; m_rid = 0; m_rdata = 0;
    endtask

    // One clock: drive inputs, check against the model mid-cycle, advance.
    // exp_w >= 0 expects that grant, -1 expects no grant, -2 no directed check.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                         input int exp_w, output int w);
        int start, excl, nptr, nrun, eaddr, j;
        req  = r;
        lock = l;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(a[i]);
        @(negedge vga_clk);
        w = -1;
        excl = -1;
        if (m_run > 0 && r[m_prev] && l[m_prev] && m_run < MB) begin
            w = m_prev; nrun = m_run + 1; nptr = m_ptr;
        end else begin
            start = (m_run > 0) ? (m_prev + 1) % N : m_ptr;
            if (m_run == MB) excl = m_prev;
            for (int k = 0; k < N; k++) begin
                j = (start + k) % N;
                if (w < 0 && r[j] && j != excl) w = j;
            end
            nptr = start;
            nrun = 0;
            if (w >= 0) begin
                if (l[w]) nrun = 1;
                else      nptr = (w + 1) % N;
            end
        end
        eaddr = (w >= 0) ? a[w] : m_last;
        chk("gnt", 32'(gnt), (w >= 0) ? (1 << w) : 0);
        if (exp_w >= 0)       chk("plan_gnt", 32'(gnt), 1 << exp_w);
        else if (exp_w == -1) chk("plan_idle", 32'(gnt), 0);
        chk("rom_address", 32'(rom_address), eaddr);
        chk("rd_valid", 32'(rd_valid), int'(m_rv));
        chk("rd_id", 32'(rd_id), m_rid);
        chk("rd_data", 32'(rd_data), m_rdata);
        @(posedge vga_clk);
        if (t_v) begin
            m_rid   = t_id;
            m_rdata = rom_fn(t_addr);
        end
        m_rv   = t_v;
        t_v    = (w >= 0);
        if (w >= 0) begin
            t_id   = w;
            m_prev = w;
        end
        t_addr = eaddr;
        m_last = eaddr;
        m_ptr  = nptr;
        m_run  = nrun;
        #1;
    endtask

    // Asynchronous reset pulse asserted mid-cycle, released after an edge.
    task automatic do_reset();
        @(negedge vga_clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rom_address", 32'(rom_address), 0);
        @(posedge vga_clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_id", 32'(rd_id), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int w, pulses;
        logic [N-1:0] r, l;
        Reset = 1'b1;
        req   = 3'b111;
        lock  = '0;
        for (int i = 0; i < N; i++) a[i] = 55 + i;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(a[i]);
        repeat (3) @(posedge vga_clk);
        #1;
        chk("init_gnt", 32'(gnt), 0);
        chk("init_rom_address", 32'(rom_address), 0);
        chk("init_rd_valid", 32'(rd_valid), 0);
        chk("init_rd_id", 32'(rd_id), 0);
        chk("init_rd_data", 32'(rd_data), 0);
        Reset = 1'b0;
        model_reset();

        // Single read of address 5, returned two cycles later.
        a[0] = 5;
        cycle(3'b001, 3'b000, 0, w);
        cycle(3'b000, 3'b000, -1, w);
        chk("t1_rd_valid", 32'(rd_valid), 1);
        chk("t1_rd_id", 32'(rd_id), 0);
        chk("t1_rd_data", 32'(rd_data), rom_fn(5));
        cycle(3'b000, 3'b000, -1, w);

        // Plain round robin with everyone requesting.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(3'b111, 3'b000, k % 3, w);
        repeat (2) cycle(3'b000, 3'b000, -1, w);

        // Locked burst capped at MAX_BURST, then requester 1 gets a turn.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(3'b011, 3'b001, 0, w);
        cycle(3'b011, 3'b001, 1, w);
        cycle(3'b001, 3'b001, 0, w);
        repeat (2) cycle(3'b000, 3'b000, -1, w);

        // Lock dropped mid-burst: pending requester 2 wins immediately.
        do_reset();
        cycle(3'b101, 3'b001, 0, w);
        cycle(3'b101, 3'b001, 0, w);
        cycle(3'b101, 3'b000, 2, w);
        repeat (2) cycle(3'b000, 3'b000, -1, w);

        // Reset between grant and return discards the read.
        a[0] = 9;
        cycle(3'b001, 3'b000, 0, w);
        do_reset();
        cycle(3'b000, 3'b000, -1, w);
        cycle(3'b000, 3'b000, -1, w);
        chk("t5_rd_valid", 32'(rd_valid), 0);
        cycle(3'b110, 3'b000, 1, w);
        repeat (3) cycle(3'b000, 3'b000, -1, w);

        // Idle after a grant: address held, exactly one return.
        a[0] = 77;
        cycle(3'b001, 3'b000, 0, w);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(3'b000, 3'b000, -1, w);
            chk("t6_rom_address", 32'(rom_address), 77);
            if (rd_valid === 1'b1) pulses++;
        end
        chk("t6_pulses", 32'(pulses), 1);

        // Random traffic: requesters hold until granted, locks toggle.
        r = '0;
        l = '0;
        w = -1;
        for (int it = 0; it < 600; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r[i] = 1'b1;
                        a[i] = int'($urandom_range(0, 1023));
                    end
                end else if (w == i) begin
                    if ($urandom_range(0, 1) == 1) r[i] = 1'b0;
                    else a[i] = int'($urandom_range(0, 1023));
                end
                if ($urandom_range(0, 3) == 0) l[i] = ~l[i];
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(r, l, -2, w);
        end
        repeat (3) cycle(3'b000, 3'b000, -1, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
